// File: rtl/sprite_draw.sv
// rtl/sprite_draw.sv - XOR sprite blitter for a 128x64 monochrome framebuffer
module sprite_draw (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        fbuf_en,
  output logic        fbuf_write,
  output logic [8:0]  fbuf_addr,
  output logic [15:0] fbuf_in,
  input  logic [15:0] fbuf_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_RD0   = 3'd3;
  localparam logic [2:0] S_WR0   = 3'd4;
  localparam logic [2:0] S_RD1   = 3'd5;
  localparam logic [2:0] S_WR1   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]  r_state;
  logic [6:0]  r_x;
  logic [5:0]  r_y;
  logic [3:0]  r_n;
  logic [11:0] r_base;
  logic [3:0]  r_row;
  logic [15:0] r_mask0;
  logic [15:0] r_mask1;
  logic        r_collision;

  logic [31:0] w_mask32;
  logic        w_wide;
  logic [5:0]  w_line;
  logic [2:0]  w_col0;
  logic [2:0]  w_col1;
  logic [3:0]  w_row_inc;
  logic        w_last_row;
  logic [15:0] w_mask_cur;

  assign w_mask32   = {mem_data, 24'b0} >> r_x[3:0];
  // A shift beyond 8 can spill sprite bits into the next word, so the row
  // always takes the second read/write pair in that case, even for a blank byte.
  assign w_wide     = (r_x[3:0] > 4'd8);
  assign w_line     = r_y + {2'b00, r_row};
  assign w_col0     = r_x[6:4];
  assign w_col1     = r_x[6:4] + 3'd1;
  assign w_row_inc  = r_row + 4'd1;
  assign w_last_row = (w_row_inc == r_n);
  assign w_mask_cur = (r_state == S_WR1) ? r_mask1 : r_mask0;

  // Draw sequencer: one sprite row per FETCH..WR pass, XOR into framebuffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= 7'd0;
      r_y         <= 6'd0;
      r_n         <= 4'd0;
      r_base      <= 12'd0;
      r_row       <= 4'd0;
      r_mask0     <= 16'd0;
      r_mask1     <= 16'd0;
      r_collision <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x         <= x;
            r_y         <= y;
            r_n         <= n;
            r_base      <= i_addr;
            r_row       <= 4'd0;
            r_collision <= 1'b0;
            r_state     <= (n == 4'd0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_mask0 <= w_mask32[31:16];
          r_mask1 <= w_mask32[15:0];
          r_state <= S_RD0;
        end
        S_RD0: r_state <= S_WR0;
        S_WR0: begin
          if ((fbuf_out & r_mask0) != 16'd0) r_collision <= 1'b1;
          if (w_wide) begin
            r_state <= S_RD1;
          end else begin
            r_row   <= w_row_inc;
            r_state <= w_last_row ? S_DONE : S_FETCH;
          end
        end
        S_RD1: r_state <= S_WR1;
        S_WR1: begin
          if ((fbuf_out & r_mask1) != 16'd0) r_collision <= 1'b1;
          r_row   <= w_row_inc;
          r_state <= w_last_row ? S_DONE : S_FETCH;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory and framebuffer strobes decoded from state; quiet outside access states
  always_comb begin
    mem_rd     = 1'b0;
    mem_addr   = 12'd0;
    fbuf_en    = 1'b0;
    fbuf_write = 1'b0;
    fbuf_addr  = 9'd0;
    fbuf_in    = 16'd0;
    case (r_state)
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = r_base + {8'd0, r_row};
      end
      S_RD0: begin
        fbuf_en   = 1'b1;
        fbuf_addr = {w_line, w_col0};
      end
      S_WR0: begin
        fbuf_en    = 1'b1;
        fbuf_write = 1'b1;
        fbuf_addr  = {w_line, w_col0};
        fbuf_in    = fbuf_out ^ w_mask_cur;
      end
      S_RD1: begin
        fbuf_en   = 1'b1;
        fbuf_addr = {w_line, w_col1};
      end
      S_WR1: begin
        fbuf_en    = 1'b1;
        fbuf_write = 1'b1;
        fbuf_addr  = {w_line, w_col1};
        fbuf_in    = fbuf_out ^ w_mask_cur;
      end
      default: begin
        mem_rd = 1'b0;
      end
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign collision = r_collision;

endmodule

// File: tb/tb_sprite_draw.sv
// tb/tb_sprite_draw.sv - directed scoreboard bench for sprite_draw
module tb_sprite_draw;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  n;
  logic [11:0] i_addr;
  logic        busy, done, collision;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        fbuf_en, fbuf_write;
  logic [8:0]  fbuf_addr;
  logic [15:0] fbuf_in;
  logic [15:0] fbuf_out;

  logic [7:0]  pmem [0:4095];
  logic [15:0] fb   [0:511];
  logic        tb_clear = 1'b0;
  logic        tb_poke  = 1'b0;
  logic [8:0]  poke_addr = 9'd0;
  logic [15:0] poke_data = 16'd0;
  int          wr_cnt  = 0;
  int          act_cnt = 0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   cyc;
    logic col;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sprite_draw dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .n(n), .i_addr(i_addr),
    .busy(busy), .done(done), .collision(collision),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .fbuf_en(fbuf_en), .fbuf_write(fbuf_write), .fbuf_addr(fbuf_addr),
    .fbuf_in(fbuf_in), .fbuf_out(fbuf_out)
  );

  // Program memory model: data one cycle after mem_rd
  always @(posedge clk) begin
    if (mem_rd) mem_data <= pmem[mem_addr];
  end

  // Framebuffer model plus bench-side clear/poke port and activity counters
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 512; i++) fb[i] <= 16'd0;
    end else if (tb_poke) begin
      fb[poke_addr] <= poke_data;
    end else if (fbuf_en && fbuf_write) begin
      fb[fbuf_addr] <= fbuf_in;
    end
    if (fbuf_en && !fbuf_write) fbuf_out <= fb[fbuf_addr];
    if (fbuf_en && fbuf_write) wr_cnt <= wr_cnt + 1;
    if (fbuf_en || mem_rd) act_cnt <= act_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check({pfx, "_done"}, {31'd0, done}, 32'd0);
    check({pfx, "_coll"}, {31'd0, collision}, 32'd0);
    check({pfx, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    check({pfx, "_fbuf_en"}, {31'd0, fbuf_en}, 32'd0);
    check({pfx, "_fbuf_write"}, {31'd0, fbuf_write}, 32'd0);
    check({pfx, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    check({pfx, "_fbuf_addr"}, {23'd0, fbuf_addr}, 32'd0);
    check({pfx, "_fbuf_in"}, {16'd0, fbuf_in}, 32'd0);
  endtask

  task automatic poke(input logic [8:0] a, input logic [15:0] d);
    poke_addr = a;
    poke_data = d;
    tb_poke   = 1'b1;
    @(posedge clk); #1;
    tb_poke   = 1'b0;
  endtask

  task automatic run_draw(input logic [6:0] px, input logic [5:0] py, input logic [3:0] pn,
                          input logic [11:0] pa, input int ecyc, input logic ecol,
                          input int glitch_cyc);
    exp_t e;
    int   cyc;
    e.cyc = ecyc;
    e.col = ecol;
    sb.push_back(e);
    x = px; y = py; n = pn; i_addr = pa;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) begin
        check("busy_during_draw", {31'd0, busy}, 32'd1);
      end
      if (cyc == glitch_cyc) begin
        start = 1'b1; n = 4'd5; x = 7'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    check("done_seen", {31'd0, done}, 32'd1);
    check("done_cycle", cyc, e.cyc);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("collision", {31'd0, collision}, {31'd0, e.col});
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int snap;
    int cyc;
    reset = 1'b1; start = 1'b0; x = '0; y = '0; n = '0; i_addr = '0;
    for (int i = 0; i < 4096; i++) pmem[i] = 8'h00;
    pmem[12'h200] = 8'hF0;
    pmem[12'h300] = 8'hFF;
    pmem[12'h400] = 8'hFF;
    pmem[12'h401] = 8'h81;
    pmem[12'h500] = 8'hAA;
    pmem[12'h501] = 8'h55;
    pmem[12'h502] = 8'h3C;
    tb_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tb_clear = 1'b0;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // single-row draw onto a clear buffer, then the same draw erases it
    run_draw(7'd0, 6'd0, 4'd1, 12'h200, 5, 1'b0, 0);
    check("t1_word0", {16'd0, fb[0]}, 32'h0000F000);
    run_draw(7'd0, 6'd0, 4'd1, 12'h200, 5, 1'b1, 0);
    check("t2_word0", {16'd0, fb[0]}, 32'h00000000);

    // n=0: no access, collision cleared by the accepted start
    snap = act_cnt;
    run_draw(7'd5, 6'd5, 4'd0, 12'h200, 1, 1'b0, 0);
    check("t5_no_activity", act_cnt - snap, 0);

    // straddling row with a start pulse ignored while busy
    run_draw(7'd12, 6'd3, 4'd1, 12'h300, 7, 1'b0, 3);
    check("t3_word24", {16'd0, fb[24]}, 32'h0000000F);
    check("t3_word25", {16'd0, fb[25]}, 32'h0000F000);

    // horizontal and vertical wrap
    run_draw(7'd124, 6'd63, 4'd2, 12'h400, 13, 1'b0, 0);
    check("t4_word511", {16'd0, fb[511]}, 32'h0000000F);
    check("t4_word504", {16'd0, fb[504]}, 32'h0000F000);
    check("t4_word7", {16'd0, fb[7]}, 32'h00000008);
    check("t4_word0", {16'd0, fb[0]}, 32'h00001000);

    // blank sprite byte still does its read/write with unchanged data
    poke(9'd80, 16'h1234);
    snap = wr_cnt;
    run_draw(7'd0, 6'd10, 4'd1, 12'h210, 5, 1'b0, 0);
    check("t6_word80", {16'd0, fb[80]}, 32'h00001234);
    check("t6_writes", wr_cnt - snap, 1);

    // reset in WR0 of row 1 of a 3-row draw
    poke(9'd168, 16'hBEEF);
    x = 7'd0; y = 6'd20; n = 4'd3; i_addr = 12'h500;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t7_in_wr0", {31'd0, fbuf_write}, 32'd1);
    check("t7_wr0_addr", {23'd0, fbuf_addr}, 32'd168);
    snap = wr_cnt;
    reset = 1'b1;
    #1;
    check_reset_outputs("t7");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) begin
        check("t7_quiet_after_reset", {30'd0, done, busy}, 32'd0);
      end
    end
    check("t7_no_writes", wr_cnt - snap, 0);
    check("t7_row1_word", {16'd0, fb[168]}, 32'h0000BEEF);
    check("t7_row0_word", {16'd0, fb[160]}, 32'h0000AA00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
